// File: rtl/alu_divider.sv
// Sequential restoring divider: DW-bit dividend by VW-bit divisor, one quotient bit per clock.
// Optional macro ALU_DIV_ZERO_CNT_EN adds a saturating divide-by-zero request counter (dz_count).
module alu_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
`ifdef ALU_DIV_ZERO_CNT_EN
    ,
    output logic [7:0]    dz_count
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int CW = $clog2(DW + 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [VW-1:0] rem_q, rem_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic          dz_q, dz_d;
    logic [VW:0]   part;
    logic [VW:0]   diff;
    logic          fits;
    logic          accept;

    assign accept = in_valid && (state_q == S_IDLE);

    // rem_q < divisor always holds, so part - divisor stays below 2^VW when it fits
    // and bit VW of the difference acts as the borrow flag.
    always_comb begin
        part = {rem_q, quot_q[DW-1]};
        diff = part - {1'b0, dvs_q};
        fits = ~diff[VW];
    end

    // quot_q starts as the dividend and shifts left, collecting quotient bits at the LSB.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_BUSY;
                    dvs_d   = divisor;
                    dz_d    = (divisor == '0);
                    if (divisor == '0) begin
                        // Zero divisor takes one settle pass through BUSY with results preloaded.
                        quot_d = '1;
                        rem_d  = dividend[VW-1:0];
                        cnt_d  = CW'(DW - 1);
                    end else begin
                        quot_d = dividend;
                        rem_d  = '0;
                        cnt_d  = '0;
                    end
                end
            end
            S_BUSY: begin
                if (!dz_q) begin
                    quot_d = {quot_q[DW-2:0], fits};
                    rem_d  = fits ? diff[VW-1:0] : part[VW-1:0];
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            dz_q    <= dz_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dz_q;

`ifdef ALU_DIV_ZERO_CNT_EN
    logic [7:0] dzc_q, dzc_d;

    always_comb begin
        dzc_d = dzc_q;
        if (accept && (divisor == '0) && (dzc_q != 8'hFF)) begin
            dzc_d = dzc_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dzc_q <= 8'd0;
        end else begin
            dzc_q <= dzc_d;
        end
    end

    assign dz_count = dzc_q;
`endif

endmodule

// File: tb/tb_alu_divider.sv
// Self-checking bench for alu_divider: directed scenarios, exhaustive sweep and randomized traffic
// checked against a plain-arithmetic division model.
module tb_alu_divider;

    localparam int DW = 8;
    localparam int VW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;
`ifdef ALU_DIV_ZERO_CNT_EN
    logic [7:0]    dz_count;
`endif

    int checks;
    int failures;

    alu_divider #(.DW(DW), .VW(VW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
`ifdef ALU_DIV_ZERO_CNT_EN
        ,
        .dz_count   (dz_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer division, with the fixed pattern for a zero divisor.
    task automatic ref_div(input int a, input int b, output int q, output int r, output bit dz);
        if (b == 0) begin
            q  = (1 << DW) - 1;
            r  = a % (1 << VW);
            dz = 1'b1;
        end else begin
            q  = a / b;
            r  = a % b;
            dz = 1'b0;
        end
    endtask

    // Stimulus helpers; callers sit 1 time unit after a rising edge.
    task automatic start(input int a, input int b);
        dividend = DW'(a);
        divisor  = VW'(b);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = DW'($urandom);
        divisor  = VW'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b q=%0d r=%0d dz=%b, want 0 0 0 0",
                     out_valid, quotient, remainder, div_by_zero);
        end
`ifdef ALU_DIV_ZERO_CNT_EN
        checks++;
        if (dz_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_dz_count: got %0d want 0", dz_count);
        end
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        int lat;
        start(200, 13);
        wait_valid(lat);
        checks++;
        if (lat != 8) begin
            failures++;
            $display("FAIL basic_latency: got %0d edges want 8", lat);
        end
        checks++;
        if (quotient !== 8'd15 || remainder !== 4'd5 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL basic_result: got q=%0d r=%0d dz=%b want q=15 r=5 dz=0",
                     quotient, remainder, div_by_zero);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat;
        start(255, 1);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_busy_ready: got %b want 0", in_ready);
        end
        wait_valid(lat);
        checks++;
        if (out_valid !== 1'b1 || quotient !== 8'd255 || remainder !== 4'd0) begin
            failures++;
            $display("FAIL b2b_first: got v=%b q=%0d r=%0d want v=1 q=255 r=0",
                     out_valid, quotient, remainder);
        end
        // Second request offered during the consuming cycle must not be taken then.
        dividend  = 8'd7;
        divisor   = 4'd9;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_no_overlap: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second_accept: got in_ready=%b want 0", in_ready);
        end
        wait_valid(lat);
        checks++;
        if (lat != 8 || quotient !== 8'd0 || remainder !== 4'd7) begin
            failures++;
            $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d want lat=8 q=0 r=7", lat, quotient, remainder);
        end
        consume();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready_after: got %b want 1", in_ready);
        end
    endtask

    task automatic test_div_zero();
        int lat;
        start(100, 0);
        wait_valid(lat);
        checks++;
        if (lat != 1) begin
            failures++;
            $display("FAIL dz_latency: got %0d edges want 1", lat);
        end
        checks++;
        if (quotient !== 8'd255 || remainder !== 4'd4 || div_by_zero !== 1'b1) begin
            failures++;
            $display("FAIL dz_result: got q=%0d r=%0d dz=%b want q=255 r=4 dz=1",
                     quotient, remainder, div_by_zero);
        end
`ifdef ALU_DIV_ZERO_CNT_EN
        checks++;
        if (dz_count !== 8'd1) begin
            failures++;
            $display("FAIL dz_count_inc: got %0d want 1", dz_count);
        end
`endif
        consume();
    endtask

    task automatic test_stall();
        int lat;
        start(200, 13);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom);
            dividend = DW'($urandom);
            divisor  = VW'($urandom);
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 8'd15 || remainder !== 4'd5) begin
                failures++;
                $display("FAIL stall_hold[%0d]: got v=%b rdy=%b q=%0d r=%0d want v=1 rdy=0 q=15 r=5",
                         i, out_valid, in_ready, quotient, remainder);
            end
        end
        in_valid = 1'b0;
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_async_reset();
        int lat;
        start(200, 13);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || quotient !== '0 || remainder !== '0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_reset: got v=%b q=%0d r=%0d rdy=%b want 0 0 0 1",
                     out_valid, quotient, remainder, in_ready);
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start(144, 12);
        wait_valid(lat);
        checks++;
        if (lat != 8 || quotient !== 8'd12 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL async_after: got lat=%0d q=%0d r=%0d dz=%b want lat=8 q=12 r=0 dz=0",
                     lat, quotient, remainder, div_by_zero);
        end
        consume();
    endtask

    task automatic test_sweep();
        int lat, q, r;
        bit dz;
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                ref_div(a, b, q, r, dz);
                start(a, b);
                wait_valid(lat);
                checks++;
                if (lat != 8 || quotient !== DW'(q) || remainder !== VW'(r) || div_by_zero !== dz) begin
                    failures++;
                    $display("FAIL sweep %0d/%0d: got lat=%0d q=%0d r=%0d dz=%b want lat=8 q=%0d r=%0d dz=%b",
                             a, b, lat, quotient, remainder, div_by_zero, q, r, dz);
                end
                consume();
            end
        end
    endtask

    task automatic test_random();
        int lat, q, r, a, b, want_lat;
        bit dz;
        for (int n = 0; n < 200; n++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 15));
            ref_div(a, b, q, r, dz);
            want_lat = (b == 0) ? 1 : 8;
            start(a, b);
            wait_valid(lat);
            repeat ($urandom_range(0, 3)) begin
                in_valid = 1'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            checks++;
            if (lat != want_lat || out_valid !== 1'b1 || quotient !== DW'(q) ||
                remainder !== VW'(r) || div_by_zero !== dz) begin
                failures++;
                $display("FAIL random %0d/%0d: got lat=%0d v=%b q=%0d r=%0d dz=%b want lat=%0d q=%0d r=%0d dz=%b",
                         a, b, lat, out_valid, quotient, remainder, div_by_zero, want_lat, q, r, dz);
            end
            consume();
        end
    endtask

`ifdef ALU_DIV_ZERO_CNT_EN
    task automatic test_dz_saturate();
        int lat;
        for (int n = 0; n < 300; n++) begin
            start(int'($urandom_range(0, 255)), 0);
            wait_valid(lat);
            consume();
        end
        checks++;
        if (dz_count !== 8'd255) begin
            failures++;
            $display("FAIL dz_saturate: got %0d want 255", dz_count);
        end
    endtask
`endif

    initial begin
        checks    = 0;
        failures  = 0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_stall();
        test_async_reset();
        test_sweep();
        test_random();
`ifdef ALU_DIV_ZERO_CNT_EN
        test_dz_saturate();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
